result_index_encoder: RTL
=========================

Name: result_index_encoder

Overview:
- Reverse-direction companion to the 9-output element-select decoder in the 3x3 matrix accelerator.
- Collects per-element "done" pulses from the 9 result processing elements and latches each result.
- Encodes pending elements back to a 4-bit element index, lowest index first.
- Streams (index, data) pairs to the result writer over a valid/ready handshake, so `out_idx` can drive the decoder address directly.

Parameters:
- N, 9, number of result elements (3x3); legal range 2..16.
- IDX_W, 4, index width; must satisfy 2^IDX_W >= N.
- DATA_W, 16, width of one result element.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- clear  in  1  synchronous start-of-matrix; drops all state.
- done_in  in  N  per-element completion pulse; bit i belongs to element i.
- data_in  in  N*DATA_W  element results; element i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  out_idx/out_data hold a result.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_idx  out  IDX_W  element index 0..N-1, same encoding as the decoder address.
- out_data  out  DATA_W  result for out_idx.
- pending_cnt  out  IDX_W+1  count of latched, not-yet-issued elements.
- all_done  out  1  all N elements delivered since last clear/reset.
- dup_err  out  1  sticky; a done_in arrived for an element already pending or served.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: all outputs 0. Internal pending[N], served[N] and data registers are 0.
- Capture: done_in[i]=1 on an edge where pending[i]=0 and served[i]=0 sets pending[i]. The same edge stores data_in slice i.
- Duplicate pulse: done_in[i] while pending[i] or served[i] is ignored (first data is kept) and sets dup_err.
- Multiple done_in bits may assert in one cycle; all are captured.
- Selection: combinational lowest-index set bit of pending; sel_any = |pending.
- Output register load condition: on an edge where (!out_valid | out_ready) and sel_any:
  - out_idx <= selected index; out_data <= its data; out_valid <= 1.
  - pending[sel] <= 0; served[sel] <= 1.
- Output register drain: (out_valid & out_ready) with !sel_any sets out_valid <= 0.
- Holding: while out_valid & !out_ready, out_idx/out_data are stable.
- Throughput: one element per cycle when out_ready is held high.
- Latency: done_in at edge k gives out_valid at edge k+1 if the output stage is free and no lower index is pending.
- Capture and selection on the same edge: an element captured at edge k is not selectable until edge k+1 (pending is registered).
- pending_cnt = popcount(pending), registered; it updates together with pending.
- all_done = (served == all ones) & !out_valid. It stays high until clear.
- clear: on the next edge, pending, served, out_valid, dup_err and pending_cnt all go to 0.
  - clear overrides done_in and any handshake in the same cycle.
  - A result held in the output register is discarded.
- Reset mid-transfer: same as clear, but asynchronous. No partial handshake survives.
- out_idx never exceeds N-1. Codes N..2^IDX_W-1 are never produced.

Decomposition:
- Shared package `result_idx_pkg`:
  - constants N_ELEM=9, IDX_W=4, DATA_W=16.
  - function `popcount`.
- One combinational sub-module, `prio_encoder_lsb` (N to IDX_W):
  - inputs: req[N].
  - outputs: idx, any.
  - it is the exact inverse of the decoder for one-hot inputs.
- The top level holds the pending/served/data registers, the output stage and the counters.

Test Plan:
- Reset mid-transfer: reset, then done_in=9'h001 with data 0x1111, out_ready=1 -> one cycle later out_valid=1, out_idx=0, out_data=0x1111. Then assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid, pending_cnt, all_done and dup_err drop to 0 immediately.
- Priority and full drain: done_in=9'h1FF in one cycle with data_i=i*0x10, out_ready=1 -> indices 0..8 on consecutive cycles with matching data. pending_cnt goes 9,8,...,0; all_done=1 after index 8 is accepted.
- Backpressure: done_in=9'h104, out_ready=0 for 5 cycles -> out_idx=2 held stable, pending_cnt=1. Raise out_ready -> idx 2 then idx 8, then out_valid=0.
- Duplicate: done_in[3] pulsed twice with data 0xAAAA then 0xBBBB -> single issue of idx 3 with 0xAAAA, dup_err=1 (sticky).
- Clear collision: clear=1 together with done_in=9'h010 while out_valid=1 -> next cycle out_valid=0, pending_cnt=0, dup_err=0. No idx 4 is ever emitted.
- Lower index arriving later: done_in[7] at cycle 0, done_in[1] at cycle 1, out_ready=0 until cycle 3 -> idx 7 is emitted first (already loaded), then idx 1.

Source files
------------

// File: rtl/result_idx_pkg.sv
// Shared constants and helpers for the result index encoder.
package result_idx_pkg;

  localparam int N_ELEM = 9;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 16;

  // Largest supported element count, sizes the popcount helper.
  localparam int MAX_N = 16;
  localparam int CNT_W = $clog2(MAX_N) + 1;

  // Number of set bits in a request vector, zero-extended to MAX_N bits.
  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/result_index_encoder_prio.sv
// Lowest-index-first priority encoder; inverse of the element-select decoder.
module prio_encoder_lsb #(
  parameter int N     = 9,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/result_index_encoder.sv
// Collects per-element done pulses, latches each result and streams
// (index, data) pairs lowest index first over a valid/ready handshake.
module result_index_encoder #(
  parameter int N      = result_idx_pkg::N_ELEM,
  parameter int IDX_W  = result_idx_pkg::IDX_W,
  parameter int DATA_W = result_idx_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [N-1:0]          done_in,
  input  logic [N*DATA_W-1:0]   data_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_idx,
  output logic [DATA_W-1:0]     out_data,
  output logic [IDX_W:0]        pending_cnt,
  output logic                  all_done,
  output logic                  dup_err
);

  import result_idx_pkg::*;

  logic [N-1:0]      pending;
  logic [N-1:0]      served;
  logic [DATA_W-1:0] data_q [N];

  logic [IDX_W-1:0]  sel_idx;
  logic              sel_any;
  logic              load;
  logic [N-1:0]      capture;
  logic [N-1:0]      dup_hit;
  logic [N-1:0]      load_mask;
  logic [N-1:0]      next_pending;

  prio_encoder_lsb #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_prio (
    .req (pending),
    .idx (sel_idx),
    .any (sel_any)
  );

  // Decide this edge's captures, duplicates and output-stage load.
  always_comb begin
    load         = (!out_valid || out_ready) && sel_any;
    capture      = done_in & ~pending & ~served;
    dup_hit      = done_in & (pending | served);
    load_mask    = '0;
    if (load) begin
      load_mask[sel_idx] = 1'b1;
    end
    next_pending = (pending & ~load_mask) | capture;
  end

  assign all_done = (&served) && !out_valid;

  // Element bookkeeping, data capture and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      served      <= '0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_data    <= '0;
      pending_cnt <= '0;
      dup_err     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        data_q[i] <= '0;
      end
    end else if (clear) begin
      pending     <= '0;
      served      <= '0;
      out_valid   <= 1'b0;
      out_idx     <= '0;
      out_data    <= '0;
      pending_cnt <= '0;
      dup_err     <= 1'b0;
    end else begin
      pending     <= next_pending;
      served      <= served | load_mask;
      pending_cnt <= (IDX_W+1)'(popcount(MAX_N'(next_pending)));
      if (|dup_hit) begin
        dup_err <= 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (capture[i]) begin
          data_q[i] <= data_in[i*DATA_W +: DATA_W];
        end
      end
      if (load) begin
        out_valid <= 1'b1;
        out_idx   <= sel_idx;
        out_data  <= data_q[sel_idx];
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
